// File: rtl/trap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trap_ctrl - arbitrates one exception/interrupt trap, latches PC, cause and
// handler address, and offers it over a valid/ready handshake.  Rev 1.0
// ---------------------------------------------------------------------------
module trap_ctrl #(
    parameter int NSTAGE = 6,
    parameter int NINT   = 16,
    parameter int CODE_W = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FLUSH,
    input  logic                   MEM_WAIT,
    input  logic                   INT_ALLOW,
    input  logic [NINT-1:0]        INT_PEND,
    input  logic [NINT-1:0]        INT_MASK,
    input  logic                   EXC_EN,
    input  logic [CODE_W-1:0]      EXC_CODE,
    input  logic [32*NSTAGE-1:0]   STAGE_PC,
    input  logic [1:0]             TRAP_VEC_MODE,
    input  logic [31:0]            TRAP_VEC_BASE,
    output logic                   TRAP_VALID,
    input  logic                   TRAP_READY,
    output logic [31:0]            TRAP_PC,
    output logic [31:0]            TRAP_CODE,
    output logic [31:0]            TRAP_JMP_TO,
    output logic                   BUSY
);
    localparam int IDX_W = (NINT > 1) ? $clog2(NINT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALID = 2'd1,
        S_QUIET = 2'd2
    } state_t;

    state_t            state_q;
    logic              valid_q;
    logic              busy_q;
    logic [31:0]       pc_q;
    logic [31:0]       code_q;
    logic [31:0]       jmp_q;

    logic [NINT-1:0]   int_act;
    logic              int_any;
    logic [IDX_W-1:0]  int_idx;
    logic              take;
    logic [31:0]       base_a;
    logic [31:0]       pc_d;
    logic [31:0]       code_d;
    logic [31:0]       jmp_d;

    always_comb begin
        int_act = INT_PEND & INT_MASK;
        int_any = INT_ALLOW & (|int_act);
        take    = EXC_EN | int_any;
        base_a  = TRAP_VEC_BASE & ~32'h3;

        // Ascending scans: the last hit is the highest index.
        int_idx = '0;
        for (int i = 0; i < NINT; i++) begin
            if (int_act[i]) int_idx = IDX_W'(i);
        end
        pc_d = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            if (STAGE_PC[32*s +: 32] != 32'd0) pc_d = STAGE_PC[32*s +: 32];
        end

        if (EXC_EN) begin
            code_d = {1'b0, 31'(EXC_CODE)};
            jmp_d  = base_a;
        end else begin
            code_d = {1'b1, 31'(int_idx)};
            jmp_d  = (TRAP_VEC_MODE == 2'd1) ? base_a + (32'(int_idx) << 2) : base_a;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            pc_q    <= '0;
            code_q  <= '0;
            jmp_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!MEM_WAIT && !FLUSH && take) begin
                        pc_q    <= pc_d;
                        code_q  <= code_d;
                        jmp_q   <= jmp_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (TRAP_READY) begin
                        valid_q <= 1'b0;
                        state_q <= S_QUIET;
                    end
                end
                S_QUIET: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TRAP_VALID  = valid_q;
    assign BUSY        = busy_q;
    assign TRAP_PC     = pc_q;
    assign TRAP_CODE   = code_q;
    assign TRAP_JMP_TO = jmp_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trap_ctrl - scoreboard bench for trap_ctrl.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_trap_ctrl;
    localparam int NSTAGE = 6;
    localparam int NINT   = 16;
    localparam int CODE_W = 4;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 FLUSH;
    logic                 MEM_WAIT;
    logic                 INT_ALLOW;
    logic [NINT-1:0]      INT_PEND;
    logic [NINT-1:0]      INT_MASK;
    logic                 EXC_EN;
    logic [CODE_W-1:0]    EXC_CODE;
    logic [32*NSTAGE-1:0] STAGE_PC;
    logic [1:0]           TRAP_VEC_MODE;
    logic [31:0]          TRAP_VEC_BASE;
    logic                 TRAP_VALID;
    logic                 TRAP_READY;
    logic [31:0]          TRAP_PC;
    logic [31:0]          TRAP_CODE;
    logic [31:0]          TRAP_JMP_TO;
    logic                 BUSY;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] code;
        logic [31:0] jmp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    trap_ctrl #(.NSTAGE(NSTAGE), .NINT(NINT), .CODE_W(CODE_W)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .INT_ALLOW(INT_ALLOW), .INT_PEND(INT_PEND), .INT_MASK(INT_MASK),
        .EXC_EN(EXC_EN), .EXC_CODE(EXC_CODE), .STAGE_PC(STAGE_PC),
        .TRAP_VEC_MODE(TRAP_VEC_MODE), .TRAP_VEC_BASE(TRAP_VEC_BASE),
        .TRAP_VALID(TRAP_VALID), .TRAP_READY(TRAP_READY), .TRAP_PC(TRAP_PC),
        .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        FLUSH = 0; MEM_WAIT = 0; INT_ALLOW = 0; INT_PEND = '0; INT_MASK = '0;
        EXC_EN = 0; EXC_CODE = '0; TRAP_READY = 0;
    endtask

    task automatic set_pc(input int s, input logic [31:0] v);
        STAGE_PC[32*s +: 32] = v;
    endtask

    // Completes an offered trap and returns to IDLE with quiet inputs.
    task automatic finish_handshake();
        idle_inputs();
        TRAP_READY = 1;
        tick();
        TRAP_READY = 0;
        tick();
    endtask

    // Reference model of arbitration from the current inputs.
    function automatic exp_t model();
        exp_t e;
        logic [NINT-1:0] act;
        logic [31:0] base_a;
        e      = '0;
        act    = INT_PEND & INT_MASK;
        base_a = {TRAP_VEC_BASE[31:2], 2'b00};
        for (int s = NSTAGE - 1; s >= 0; s--)
            if (e.pc == 32'd0) e.pc = STAGE_PC[32*s +: 32];
        e.jmp = base_a;
        if (EXC_EN) begin
            e.code = 32'(EXC_CODE);
        end else begin
            for (int i = NINT - 1; i >= 0; i--) begin
                if (act[i] && !e.code[31]) begin
                    e.code = 32'h8000_0000 | 32'(i);
                    if (TRAP_VEC_MODE == 2'd1) e.jmp = base_a + 32'(i * 4);
                end
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        RST = 1; idle_inputs(); STAGE_PC = '0; TRAP_VEC_MODE = 0; TRAP_VEC_BASE = '0;
        tick(); tick();
        checks++;
        if (TRAP_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", TRAP_VALID); end
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++;
        if ({TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== 96'd0) begin
            failures++; $display("FAIL reset_outs: got %h %h %h want all 0", TRAP_PC, TRAP_CODE, TRAP_JMP_TO);
        end
        RST = 0;
        tick();
    endtask

    task automatic test_exc_priority();
        exp_t e;
        idle_inputs();
        EXC_EN = 1; EXC_CODE = 4'd2; INT_ALLOW = 1; INT_PEND = 16'h0008; INT_MASK = 16'h0008;
        TRAP_VEC_BASE = 32'h8000_0100; TRAP_VEC_MODE = 2'd1;
        STAGE_PC = '0; set_pc(5, 32'h200); set_pc(2, 32'h50);
        checks++;
        if (TRAP_VALID !== 1'b0) begin failures++; $display("FAIL exc_pre_valid: got %b want 0", TRAP_VALID); end
        exp_q.push_back('{pc: 32'h200, code: 32'h2, jmp: 32'h8000_0100});
        tick();
        checks++;
        if (TRAP_VALID !== 1'b1) begin failures++; $display("FAIL exc_valid: got %b want 1", TRAP_VALID); end
        e = exp_q.pop_front();
        checks++;
        if ({TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
            failures++; $display("FAIL exc_outs: got %h %h %h want %h %h %h", TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
        end
        finish_handshake();
    endtask

    task automatic test_vectored();
        exp_t e;
        logic [1:0]  modes[2];
        logic [31:0] jmps[2];
        modes[0] = 2'd1; jmps[0] = 32'h8000_011C;
        modes[1] = 2'd3; jmps[1] = 32'h8000_0100;
        for (int m = 0; m < 2; m++) begin
            idle_inputs();
            INT_ALLOW = 1; INT_PEND = 16'h0881; INT_MASK = 16'h0081;
            TRAP_VEC_BASE = 32'h8000_0103; TRAP_VEC_MODE = modes[m];
            STAGE_PC = '0; set_pc(4, 32'h1234);
            TRAP_READY = (m == 1);
            exp_q.push_back('{pc: 32'h1234, code: 32'h8000_0007, jmp: jmps[m]});
            tick();
            checks++;
            if (TRAP_VALID !== 1'b1) begin failures++; $display("FAIL vec_valid m%0d: got %b want 1", m, TRAP_VALID); end
            e = exp_q.pop_front();
            checks++;
            if ({TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
                failures++; $display("FAIL vec_outs m%0d: got %h %h %h want %h %h %h", m, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
            end
            if (m == 0) begin
                finish_handshake();
            end else begin
                tick();
                checks++;
                if ({TRAP_VALID, BUSY} !== 2'b01) begin
                    failures++; $display("FAIL early_ready: got valid=%b busy=%b want 0 1", TRAP_VALID, BUSY);
                end
                idle_inputs();
                tick();
            end
        end
    endtask

    task automatic test_pc_select();
        exp_t e;
        idle_inputs();
        EXC_EN = 1; EXC_CODE = 4'd5; TRAP_VEC_MODE = 2'd0; TRAP_VEC_BASE = 32'h8000_0100;
        STAGE_PC = '0; set_pc(0, 32'h40); set_pc(1, 32'h3C);
        exp_q.push_back('{pc: 32'h3C, code: 32'h5, jmp: 32'h8000_0100});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (TRAP_VALID !== 1'b1 || {TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
            failures++; $display("FAIL pc_sel: got v=%b %h %h %h want 1 %h %h %h", TRAP_VALID, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
        end
        finish_handshake();
        checks++;
        if ({TRAP_VALID, BUSY} !== 2'b00 || TRAP_PC !== 32'h3C) begin
            failures++; $display("FAIL post_hold: got v=%b b=%b pc=%h want 0 0 3c", TRAP_VALID, BUSY, TRAP_PC);
        end
        STAGE_PC = '0; EXC_EN = 1; EXC_CODE = 4'hF;
        exp_q.push_back('{pc: 32'h0, code: 32'hF, jmp: 32'h8000_0100});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (TRAP_VALID !== 1'b1 || {TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
            failures++; $display("FAIL pc_zero: got v=%b %h %h %h want 1 %h %h %h", TRAP_VALID, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
        end
        finish_handshake();
    endtask

    task automatic test_handshake_hold();
        exp_t e;
        idle_inputs();
        INT_ALLOW = 1; INT_PEND = 16'h8001; INT_MASK = 16'h8001;
        TRAP_VEC_MODE = 2'd1; TRAP_VEC_BASE = 32'h8000_0000;
        STAGE_PC = '0; set_pc(5, 32'h700);
        exp_q.push_back('{pc: 32'h700, code: 32'h8000_000F, jmp: 32'h8000_003C});
        tick();
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({TRAP_VALID, BUSY} !== 2'b11 || {TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
                failures++; $display("FAIL hold c%0d: got v=%b b=%b %h %h %h want 1 1 %h %h %h", k, TRAP_VALID, BUSY, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
            end
            FLUSH = k[0]; MEM_WAIT = ~k[0]; EXC_EN = k[1]; EXC_CODE = 4'(k);
            INT_PEND = 16'($urandom); set_pc(5, $urandom);
            tick();
        end
        idle_inputs();
        TRAP_READY = 1;
        tick();
        checks++;
        if ({TRAP_VALID, BUSY} !== 2'b01) begin failures++; $display("FAIL quiet: got v=%b b=%b want 0 1", TRAP_VALID, BUSY); end
        TRAP_READY = 0;
        tick();
        checks++;
        if ({TRAP_VALID, BUSY} !== 2'b00) begin failures++; $display("FAIL idle_back: got v=%b b=%b want 0 0", TRAP_VALID, BUSY); end
    endtask

    task automatic test_stall_flush();
        exp_t e;
        idle_inputs();
        EXC_EN = 1; EXC_CODE = 4'd3; MEM_WAIT = 1;
        TRAP_VEC_MODE = 2'd0; TRAP_VEC_BASE = 32'h8000_0100;
        STAGE_PC = '0; set_pc(5, 32'h900);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({TRAP_VALID, BUSY} !== 2'b00) begin failures++; $display("FAIL stall c%0d: got v=%b b=%b want 0 0", k, TRAP_VALID, BUSY); end
        end
        MEM_WAIT = 0; FLUSH = 1;
        tick();
        checks++;
        if (TRAP_VALID !== 1'b0) begin failures++; $display("FAIL flush: got %b want 0", TRAP_VALID); end
        FLUSH = 0;
        exp_q.push_back('{pc: 32'h900, code: 32'h3, jmp: 32'h8000_0100});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (TRAP_VALID !== 1'b1 || {TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
            failures++; $display("FAIL clean: got v=%b %h %h %h want 1 %h %h %h", TRAP_VALID, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
        end
        finish_handshake();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        idle_inputs();
        INT_ALLOW = 1; INT_PEND = 16'h0010; INT_MASK = 16'h0010; TRAP_READY = 1;
        TRAP_VEC_MODE = 2'd1; TRAP_VEC_BASE = 32'h8000_0100;
        STAGE_PC = '0; set_pc(3, 32'hABC);
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) exp_q.push_back('{pc: 32'hABC, code: 32'h8000_0004, jmp: 32'h8000_0110});
            tick();
            checks++;
            if (TRAP_VALID !== (c % 3 == 0)) begin
                failures++; $display("FAIL b2b_valid c%0d: got %b want %0d", c, TRAP_VALID, (c % 3 == 0));
            end
            if (c % 3 == 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
                    failures++; $display("FAIL b2b_outs c%0d: got %h %h %h want %h %h %h", c, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        idle_inputs();
        EXC_EN = 1; EXC_CODE = 4'd6; TRAP_VEC_MODE = 2'd0; TRAP_VEC_BASE = 32'h8000_0200;
        STAGE_PC = '0; set_pc(5, 32'h444);
        exp_q.push_back('{pc: 32'h444, code: 32'h6, jmp: 32'h8000_0200});
        tick();
        checks++;
        if (TRAP_VALID !== 1'b1) begin failures++; $display("FAIL rst_pre: got %b want 1", TRAP_VALID); end
        RST = 1;
        exp_q.delete();
        tick();
        checks++;
        if ({TRAP_VALID, BUSY} !== 2'b00 || {TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== 96'd0) begin
            failures++; $display("FAIL rst_mid: got v=%b b=%b %h %h %h want all 0", TRAP_VALID, BUSY, TRAP_PC, TRAP_CODE, TRAP_JMP_TO);
        end
        RST = 0; EXC_EN = 0;
        tick();
        EXC_EN = 1;
        exp_q.push_back('{pc: 32'h444, code: 32'h6, jmp: 32'h8000_0200});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (TRAP_VALID !== 1'b1 || {TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
            failures++; $display("FAIL rst_after: got v=%b %h %h %h want 1 %h %h %h", TRAP_VALID, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
        end
        finish_handshake();
    endtask

    task automatic test_random();
        exp_t e;
        int   idx;
        for (int n = 0; n < 16; n++) begin
            idle_inputs();
            EXC_EN = 1'($urandom); EXC_CODE = 4'($urandom);
            INT_PEND = 16'($urandom); INT_MASK = 16'($urandom);
            INT_ALLOW = 1'($urandom);
            if (!EXC_EN) begin
                INT_ALLOW = 1;
                idx = int'($urandom_range(0, NINT - 1));
                INT_PEND[idx] = 1'b1; INT_MASK[idx] = 1'b1;
            end
            TRAP_VEC_MODE = 2'($urandom); TRAP_VEC_BASE = $urandom;
            for (int s = 0; s < NSTAGE; s++) set_pc(s, ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom);
            exp_q.push_back(model());
            tick();
            e = exp_q.pop_front();
            checks++;
            if (TRAP_VALID !== 1'b1 || {TRAP_PC, TRAP_CODE, TRAP_JMP_TO} !== e) begin
                failures++; $display("FAIL rand n%0d: got v=%b %h %h %h want 1 %h %h %h", n, TRAP_VALID, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, e.pc, e.code, e.jmp);
            end
            finish_handshake();
        end
    endtask

    initial begin
        test_reset();
        test_exc_priority();
        test_vectored();
        test_pc_select();
        test_handshake_hold();
        test_stall_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised trap controller for the Sasanqua pipeline. It samples the exception from the cushion stage, a vector of maskable interrupt lines and the PCs of all pipeline stages. It arbitrates one trap, latches the trap PC, cause and jump target, and offers the trap to the CSR/fetch side over a valid/ready handshake. It sits beside the pipeline, downstream of the cushion stage, and generalises the single-source, fixed-stage trap unit to N stages, N interrupt sources and correct vectored mode.

## Interface
- NSTAGE, 6: number of stage PCs; index 0 = fetch, NSTAGE-1 = oldest (cushion).
- NINT, 16: interrupt sources, 1..64.
- CODE_W, 4: exception code width, 1..31.
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- FLUSH  in  1  pipeline flush; discards sampled, not-yet-offered state.
- MEM_WAIT  in  1  memory stall; freezes sampling.
- INT_ALLOW  in  1  global interrupt enable (mstatus.MIE equivalent).
- INT_PEND  in  NINT  pending interrupt lines.
- INT_MASK  in  NINT  per-line enable (mie equivalent).
- EXC_EN  in  1  cushion-stage exception.
- EXC_CODE  in  CODE_W  exception cause.
- STAGE_PC  in  32*NSTAGE  packed stage PCs; stage i = bits [32i+31:32i]; 0 = bubble.
- TRAP_VEC_MODE  in  2  0 direct, 1 vectored, 2/3 treated as direct.
- TRAP_VEC_BASE  in  32  trap vector base.
- TRAP_VALID  out  1  trap offered.
- TRAP_READY  in  1  consumer accepts trap.
- TRAP_PC  out  32  PC of the trapping instruction.
- TRAP_CODE  out  32  mcause-format cause.
- TRAP_JMP_TO  out  32  handler address.
- BUSY  out  1  state != IDLE.

## Operation
- States: IDLE, VALID, QUIET. Reset -> IDLE.
- IDLE, MEM_WAIT=1: nothing is sampled and the state stays IDLE.
- IDLE, FLUSH=1 (MEM_WAIT=0): nothing is sampled and the state stays IDLE. FLUSH takes priority over trap detection in the same cycle.
- IDLE, no FLUSH, no MEM_WAIT: the trap condition is EXC_EN or (INT_ALLOW and |(INT_PEND & INT_MASK)).
  - If the condition is true, latch the outputs and go to VALID.
  - If false, stay in IDLE.
- Arbitration: an exception beats any interrupt. Among interrupts, the highest active index wins.
- TRAP_CODE:
  - Exception: {0, zero-extended EXC_CODE}.
  - Interrupt: {1'b1, zero-extended winning index}.
- TRAP_JMP_TO: base_a = {TRAP_VEC_BASE[31:2], 2'b00}.
  - Mode 1 with an interrupt: base_a + (index << 2), mod 2^32.
  - Every other case: base_a. Exceptions always go to base_a.
- TRAP_PC: PC of the highest-index stage whose PC is nonzero. If every stage PC is 0, TRAP_PC = 0.
- VALID:
  - TRAP_VALID=1 and all outputs are held stable.
  - FLUSH, MEM_WAIT and input changes are ignored. A trap that has been offered is never dropped.
  - When TRAP_READY=1 the handshake completes and the state goes to QUIET.
- QUIET: one cycle with inputs ignored, covering the pipeline flush issued by the consumer. Then go to IDLE.
- Outputs keep their last latched values after the handshake until the next trap is latched.

## Timing
- Reset values: TRAP_VALID=0, BUSY=0, TRAP_PC=0, TRAP_CODE=0, TRAP_JMP_TO=0.
- Latency: a trap condition sampled on edge t gives TRAP_VALID=1 from t+1.
- TRAP_READY may be high before TRAP_VALID rises. If TRAP_READY is already high when TRAP_VALID first rises, the handshake completes on the first VALID edge.
- Minimum trap-to-trap spacing is 3 cycles: VALID, QUIET, then a new sample in IDLE.
- An interrupt that deasserts during VALID or QUIET does not affect the latched trap.
- An interrupt still pending after QUIET is taken again.
- RST mid-VALID: TRAP_VALID drops on the next edge; no handshake occurs.
- All outputs are driven from registers; there is no combinational path from any input to any output.

## Test plan
- Exception priority: EXC_EN=1, EXC_CODE=2, INT_ALLOW=1, PEND=MASK=0x0008, base 0x80000100, mode 1 -> next cycle VALID, CODE=0x00000002, JMP_TO=0x80000100.
- Vectored interrupt: PEND=0x0881, MASK=0x0081, ALLOW=1, base 0x80000103, mode 1 -> CODE=0x80000007, JMP_TO=0x8000011C. Repeat with mode 3 -> JMP_TO=0x80000100.
- PC select: stage PCs {f=0x40, d=0x3C, others 0} -> TRAP_PC=0x3C. All stage PCs 0 -> TRAP_PC=0.
- Handshake hold: trap offered, READY held low 5 cycles while FLUSH, MEM_WAIT and PEND toggle -> VALID and all outputs stable; READY=1 -> VALID=0 next cycle, BUSY=1 for one QUIET cycle, then 0.
- Stall/flush gating: MEM_WAIT=1 with EXC_EN=1 for 3 cycles -> no VALID. Then FLUSH=1 with EXC_EN=1 -> no VALID. Next clean cycle with EXC_EN=1 -> VALID.
- Reset mid-operation: RST during VALID -> VALID=0 and all outputs 0 after the edge; a trap condition one cycle after RST releases -> VALID 1 cycle later.
